buf_reduce_node: RTL and testbench

//  Parametrised gather/reduce node for the processor tree. Waits until every

---
 rtl/buf_reduce_node.sv | 159 +++++++++++++++
 tb/tb_buf_reduce_node.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/buf_reduce_node.sv
// rtl/buf_reduce_node.sv - gather/reduce node: snapshot child pairs, fold min/max/sum, hand result upward
module buf_reduce_node #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [1:0]               mode,
    input  logic [NUM_CH-1:0]        ch_flag,
    input  logic [NUM_CH*DATA_W-1:0] ch_val1,
    input  logic [NUM_CH*DATA_W-1:0] ch_val2,
    input  logic [IDX_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]        rd_val1,
    output logic [DATA_W-1:0]        rd_val2,
    output logic [DATA_W-1:0]        res_val1,
    output logic [DATA_W-1:0]        res_val2,
    output logic [IDX_W-1:0]         res_idx,
    output logic                     res_valid,
    input  logic                     res_ack,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, REDUCE, DONE, DRAIN} state_t;

    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_SUM = 2'b10;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] snap_v1 [NUM_CH];
    logic [DATA_W-1:0] snap_v2 [NUM_CH];
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] acc_v1;
    logic [DATA_W-1:0] acc_v2;
    logic [IDX_W-1:0]  acc_idx;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] cur_v1;
    logic [DATA_W-1:0] cur_v2;
    logic              win;
    logic              all_flags;

    assign all_flags = &ch_flag;
    assign busy      = (state != IDLE);

    // Select the snapshot channel currently being folded
    always_comb begin
        cur_v1 = '0;
        cur_v2 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt == IDX_W'(i)) begin
                cur_v1 = snap_v1[i];
                cur_v2 = snap_v2[i];
            end
        end
    end

    // Strict-win compare; ties keep the lower (already held) index, mode 11 behaves as MIN
    always_comb begin
        win = 1'b0;
        case (mode_q)
            MODE_MAX: win = (cur_v1 > acc_v1);
            MODE_SUM: win = 1'b0;
            default:  win = (cur_v1 < acc_v1);
        endcase
    end

    // Raw read port into the snapshot; out-of-range addresses read as zero
    always_comb begin
        rd_val1 = '0;
        rd_val2 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_val1 = snap_v1[i];
                rd_val2 = snap_v2[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: DRAIN waits for all flags low so stale data is never recaptured
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (all_flags) state_nxt = REDUCE;
            REDUCE:  if (cnt == IDX_W'(NUM_CH - 1)) state_nxt = DONE;
            DONE:    if (res_valid && res_ack) state_nxt = DRAIN;
            DRAIN:   if (ch_flag == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot capture, sequential fold and result handshake
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_v1[i] <= '0;
                snap_v2[i] <= '0;
            end
            mode_q    <= '0;
            acc_v1    <= '0;
            acc_v2    <= '0;
            acc_idx   <= '0;
            cnt       <= '0;
            res_val1  <= '0;
            res_val2  <= '0;
            res_idx   <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (all_flags) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap_v1[i] <= ch_val1[i*DATA_W +: DATA_W];
                            snap_v2[i] <= ch_val2[i*DATA_W +: DATA_W];
                        end
                        mode_q  <= mode;
                        acc_v1  <= ch_val1[0 +: DATA_W];
                        acc_v2  <= ch_val2[0 +: DATA_W];
                        acc_idx <= '0;
                        cnt     <= IDX_W'(1);
                    end
                end
                REDUCE: begin
                    if (mode_q == MODE_SUM) begin
                        acc_v1 <= acc_v1 + cur_v1;
                        acc_v2 <= acc_v2 + cur_v2;
                    end else if (win) begin
                        acc_v1  <= cur_v1;
                        acc_v2  <= cur_v2;
                        acc_idx <= cnt;
                    end
                    cnt <= cnt + IDX_W'(1);
                end
                DONE: begin
                    if (!res_valid) begin
                        res_val1  <= acc_v1;
                        res_val2  <= acc_v2;
                        res_idx   <= acc_idx;
                        res_valid <= 1'b1;
                    end else if (res_ack) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_reduce_node.sv
// tb/tb_buf_reduce_node.sv - scoreboard bench for buf_reduce_node
module tb_buf_reduce_node;

    localparam int NUM_CH = 6;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 3;

    typedef struct {
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [IDX_W-1:0]  idx;
    } res_t;

    logic                     Clk;
    logic                     Reset;
    logic [1:0]               mode;
    logic [NUM_CH-1:0]        ch_flag;
    logic [NUM_CH*DATA_W-1:0] ch_val1;
    logic [NUM_CH*DATA_W-1:0] ch_val2;
    logic [IDX_W-1:0]         rd_addr;
    logic [DATA_W-1:0]        rd_val1;
    logic [DATA_W-1:0]        rd_val2;
    logic [DATA_W-1:0]        res_val1;
    logic [DATA_W-1:0]        res_val2;
    logic [IDX_W-1:0]         res_idx;
    logic                     res_valid;
    logic                     res_ack;
    logic                     busy;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    buf_reduce_node #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .Reset(Reset), .mode(mode), .ch_flag(ch_flag),
        .ch_val1(ch_val1), .ch_val2(ch_val2), .rd_addr(rd_addr),
        .rd_val1(rd_val1), .rd_val2(rd_val2), .res_val1(res_val1),
        .res_val2(res_val2), .res_idx(res_idx), .res_valid(res_valid),
        .res_ack(res_ack), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] pack6(
        input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] a2,
        input logic [DATA_W-1:0] a3, input logic [DATA_W-1:0] a4, input logic [DATA_W-1:0] a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: pop on each new result, and require stability while valid is held
    logic              prev_valid = 1'b0;
    res_t              held;
    always @(negedge Clk) begin
        if (!Reset) begin
            prev_valid = 1'b0;
        end else if (res_valid) begin
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    held = sb.pop_front();
                    check("res_val1", 64'(res_val1), 64'(held.v1));
                    check("res_val2", 64'(res_val2), 64'(held.v2));
                    check("res_idx",  64'(res_idx),  64'(held.idx));
                end
            end else begin
                check("res_stable", {res_val1, res_val2[DATA_W-1:IDX_W], res_idx},
                      {held.v1, held.v2[DATA_W-1:IDX_W], held.idx});
            end
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic run(input logic [1:0] m,
                       input logic [NUM_CH*DATA_W-1:0] v1, input logic [NUM_CH*DATA_W-1:0] v2,
                       input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                       input logic [IDX_W-1:0] ei, input bit keep_flags, input int hold);
        res_t e;
        int   lat;
        e.v1 = e1; e.v2 = e2; e.idx = ei;
        mode = m; ch_val1 = v1; ch_val2 = v2; ch_flag = '1;
        sb.push_back(e);
        tick();
        check("capture_busy", 64'(busy), 64'd1);
        if (!keep_flags) begin
            ch_flag = '0; ch_val1 = '0; ch_val2 = '0; mode = 2'b00;
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(NUM_CH));
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", 64'(res_valid), 64'd1);
        end
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("ack_drop", 64'(res_valid), 64'd0);
        check("drain_busy", 64'(busy), 64'd1);
        if (keep_flags) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                check("drain_hold", {63'(res_valid), busy}, 64'd1);
            end
            ch_flag = '0;
        end
        tick();
        check("idle_return", 64'(busy), 64'd0);
    endtask

    logic [NUM_CH*DATA_W-1:0] tens;

    initial begin
        Reset = 1'b0; mode = 2'b00; ch_flag = '1; res_ack = 1'b0; rd_addr = '0;
        ch_val1 = '1; ch_val2 = '1;
        tens = pack6(0, 10, 20, 30, 40, 50);

        // Reset with flags all high: nothing captured
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_res", {res_val1, res_val2}, 64'd0);
        check("rst_idx", 64'(res_idx), 64'd0);
        check("rst_rd", {rd_val1, rd_val2}, 64'd0);
        ch_flag = '0; ch_val1 = '0; ch_val2 = '0;
        Reset = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);

        // Partial flags never capture; ack while not valid is ignored
        ch_flag = 6'b111110; ch_val1 = pack6(1, 2, 3, 4, 5, 6);
        res_ack = 1'b1;
        tick(); tick(); tick();
        res_ack = 1'b0;
        check("partial_flags", {63'(res_valid), busy}, 64'd0);
        ch_flag = 6'b011111;
        tick(); tick();
        check("partial_flags2", 64'(busy), 64'd0);
        ch_flag = '0;
        tick();

        // MIN with tie at index 1 and 3
        run(2'b00, pack6(9, 4, 7, 4, 12, 5), tens, 32'd4, 32'd10, 3'd1, 1'b0, 0);
        // SUM wraps modulo 2^32
        run(2'b10, pack6(32'hFFFF_FFFF, 2, 0, 0, 0, 0), tens, 32'd1, 32'd150, 3'd0, 1'b0, 0);
        // MAX with inputs zeroed and mode changed after capture
        run(2'b01, pack6(1, 2, 3, 4, 5, 6), tens, 32'd6, 32'd50, 3'd5, 1'b0, 1);

        // Raw reads come from the snapshot of the MAX run, not the zeroed live inputs
        rd_addr = 3'd3;
        #1;
        check("rd_val1_3", 64'(rd_val1), 64'd4);
        check("rd_val2_3", 64'(rd_val2), 64'd30);
        rd_addr = 3'd7;
        #1;
        check("rd_oob7", {rd_val1, rd_val2}, 64'd0);
        rd_addr = 3'd6;
        #1;
        check("rd_oob6", {rd_val1, rd_val2}, 64'd0);
        rd_addr = 3'd3;

        // Mode 11 behaves as MIN
        run(2'b11, pack6(5, 9, 2, 8, 2, 1), tens, 32'd1, 32'd50, 3'd5, 1'b0, 0);
        // MAX tie keeps lower index; held 5 cycles, flags stay high through drain
        run(2'b01, pack6(3, 8, 8, 1, 0, 2), pack6(100, 101, 102, 103, 104, 105),
            32'd8, 32'd101, 3'd1, 1'b1, 5);

        // Abort in the middle of REDUCE
        mode = 2'b00; ch_val1 = pack6(7, 6, 5, 4, 3, 2); ch_val2 = tens; ch_flag = '1;
        tick();
        ch_flag = '0;
        tick(); tick();
        check("abort_in_reduce", 64'(busy), 64'd1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_res", {res_val1, res_val2}, 64'd0);
        check("abort_rd", {rd_val1, rd_val2}, 64'd0);
        tick(); tick();
        check("abort_idle", {63'(res_valid), busy}, 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
